// File: rtl/if_id_buffer_pkg.sv
// Shared CPU constants and the fetch-entry record used by the IF/ID buffer.
package if_id_buffer_pkg;

  localparam logic [31:0] PC_BASE       = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage : if_id_buffer_pkg

// File: rtl/if_id_buffer_mem.sv
// Entry storage for the IF/ID buffer: one write port, one asynchronous read port, no reset.
module fetch_buf_mem
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  fetch_entry_t               wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output fetch_entry_t               rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fetch_buf_mem

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO of {pc, instr} pairs; head is presented combinationally to decode.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pcp4,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push, pop;
  fetch_entry_t  wr_entry, head_entry;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // flush masks both handshakes so a redirect discards the in-flight entry too
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_buf_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // Storage is never reset, so an empty buffer must mask the stale head with the nop/base values
  assign out_instr = out_valid ? head_entry.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head_entry.pc    : PC_BASE;
  assign out_pcp4  = out_pc + 32'd4;

endmodule : if_id_buffer
